// File: rtl/des_ctrl_pkg.sv
// Shared widths, defaults and payload types for the DES round-robin scheduler.
package des_ctrl_pkg;

  localparam int unsigned DES_BLK_W   = 64;
  localparam int unsigned DES_KEY_W   = 64;
  localparam int unsigned DES_LATENCY = 16;

  typedef struct packed {
    logic                 id;
    logic [DES_BLK_W-1:0] data;
  } rsp_entry_t;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/des_rsp_fifo.sv
// First-word-fallthrough result FIFO over registered storage; depth must be a power of two.
module des_rsp_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit tells full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/des_rr_scheduler.sv
// Round-robin sharing of one pipelined DES core between two requesters,
// with owner tags tracked through the core and credit-limited result buffering.
module des_rr_scheduler
  import des_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY    = DES_LATENCY,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [DES_KEY_W-1:0] req0_key,
  input  logic [DES_BLK_W-1:0] req0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [DES_KEY_W-1:0] req1_key,
  input  logic [DES_BLK_W-1:0] req1_data,
  output logic                 des_load,
  output logic [DES_KEY_W-1:0] des_key_in,
  output logic [DES_BLK_W-1:0] des_data_in,
  input  logic [DES_BLK_W-1:0] des_data_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DES_BLK_W-1:0] rsp_data,
  output logic                 rsp_id,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             last_id;
  logic             can_grant;
  logic             grant0;
  logic             grant1;
  logic             grant;
  logic             rsp_pop;
  logic             issue_id;
  tag_t             tag_pipe [LATENCY];
  tag_t             tag_exit;
  rsp_entry_t       fifo_din;
  rsp_entry_t       fifo_dout;
  logic             fifo_empty;
  logic             fifo_full;

  assign can_grant = (count < CNT_W'(FIFO_DEPTH));
  assign rsp_pop   = rsp_valid && rsp_ready;

  // Arbitration: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_grant) begin
      if (req0_valid && (!req1_valid || last_id)) grant0 = 1'b1;
      else if (req1_valid)                        grant1 = 1'b1;
    end
  end

  assign grant      = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    count_nxt = count;
    if (grant && !rsp_pop)      count_nxt = count + CNT_W'(1);
    else if (!grant && rsp_pop) count_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      busy    <= 1'b0;
      last_id <= 1'b1;
    end else begin
      count <= count_nxt;
      busy  <= (count_nxt != '0);
      if (grant) last_id <= grant1;
    end
  end

  // Issue registers hold the last block when idle so the core inputs stay quiet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      des_load    <= 1'b0;
      des_key_in  <= '0;
      des_data_in <= '0;
      issue_id    <= 1'b0;
    end else begin
      des_load <= grant;
      if (grant) begin
        des_key_in  <= grant1 ? req1_key  : req0_key;
        des_data_in <= grant1 ? req1_data : req0_data;
        issue_id    <= grant1;
      end
    end
  end

  // Owner tags travel alongside the core so each result knows its requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(LATENCY); i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: des_load, id: issue_id};
      for (int i = 1; i < int'(LATENCY); i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_exit = tag_pipe[LATENCY-1];
  assign fifo_din = '{id: tag_exit.id, data: des_data_out};

  des_rsp_fifo #(
    .WIDTH ($bits(rsp_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tag_exit.valid),
    .din   (fifo_din),
    .pop   (rsp_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_dout.data;
  assign rsp_id    = fifo_dout.id;

  // Credits bound outstanding blocks to the FIFO depth, so a result never meets a full FIFO.
  no_overflow: assert property (@(posedge clk) disable iff (!reset)
                                !(tag_exit.valid && fifo_full && !rsp_pop));

endmodule

// File: tb/tb_des_rr_scheduler.sv
// Randomized scoreboard bench for des_rr_scheduler with a behavioural DES core model.
module tb_des_rr_scheduler;

  localparam int LAT   = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_key = '0, req0_data = '0, req1_key = '0, req1_data = '0;
  logic        des_load;
  logic [63:0] des_key_in, des_data_in, des_data_out;
  logic        rsp_valid, rsp_id, busy;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  des_rr_scheduler #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_data(req1_data),
    .des_load(des_load), .des_key_in(des_key_in), .des_data_in(des_data_in),
    .des_data_out(des_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DES reference tables (bit 1 = MSB)
  byte unsigned IP_T[64]  = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                              57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  byte unsigned FP_T[64]  = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                              36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  byte unsigned E_T[48]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                              16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  byte unsigned P_T[32]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  byte unsigned PC1_T[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                              63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  byte unsigned PC2_T[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                              41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  byte unsigned SH_T[16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  byte unsigned SBOX[8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] des_enc(input logic [63:0] key, input logic [63:0] pt);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [63:0] ipv, pre, res;
    logic [31:0] l, r, f, sout, tmp;
    logic [47:0] k, er, x;
    logic [5:0]  six;
    int          row, col;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-int'(PC1_T[i])];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 64; i++) ipv[63-i] = pt[64-int'(IP_T[i])];
    l = ipv[63:32];
    r = ipv[31:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int s = 0; s < int'(SH_T[rd]); s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cd[56-int'(PC2_T[i])];
      for (int i = 0; i < 48; i++) er[47-i] = r[32-int'(E_T[i])];
      x = er ^ k;
      for (int s = 0; s < 8; s++) begin
        six = x[47-6*s -: 6];
        row = int'({six[5], six[0]});
        col = int'(six[4:1]);
        sout[31-4*s -: 4] = 4'(SBOX[s][row*16+col]);
      end
      for (int i = 0; i < 32; i++) f[31-i] = sout[32-int'(P_T[i])];
      tmp = l ^ f;
      l   = r;
      r   = tmp;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[63-i] = pre[64-int'(FP_T[i])];
    return res;
  endfunction

  // Core model: result visible LAT-1 edges after the sampling edge; idle slots carry garbage.
  logic [63:0] core_pipe [LAT];
  always @(posedge clk) begin
    core_pipe[0] <= des_load ? des_enc(des_key_in, des_data_in) : {$urandom, $urandom};
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign des_data_out = core_pipe[LAT-1];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard: expected results in grant order, each with the first cycle it may appear.
  typedef struct {
    logic        id;
    logic [63:0] data;
    int          avail;
  } exp_t;
  exp_t        sbq[$];
  logic        m_last = 1'b1;
  logic        prev_hs = 1'b0;
  logic [63:0] prev_key = '0, prev_data = '0;
  logic        exp_valid, e0, e1, can_g;

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_des_load", 64'(des_load), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      sbq.delete();
      m_last  = 1'b1;
      prev_hs = 1'b0;
    end else begin
      exp_valid = (sbq.size() > 0) && (cyc >= sbq[0].avail);
      check("busy", 64'(busy), 64'(sbq.size() != 0));
      check("des_load", 64'(des_load), 64'(prev_hs));
      if (prev_hs) begin
        check("des_key_in", des_key_in, prev_key);
        check("des_data_in", des_data_in, prev_data);
      end
      can_g = (sbq.size() < DEPTH);
      e0 = can_g && req0_valid && (!req1_valid || m_last);
      e1 = can_g && req1_valid && !e0;
      check("req0_ready", 64'(req0_ready), 64'(e0));
      check("req1_ready", 64'(req1_ready), 64'(e1));
      check("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
      if (exp_valid && rsp_valid) begin
        check("rsp_id", 64'(rsp_id), 64'(sbq[0].id));
        check("rsp_data", rsp_data, sbq[0].data);
      end
      if (exp_valid && rsp_ready) void'(sbq.pop_front());
      prev_hs = e0 || e1;
      if (e0 || e1) begin
        prev_key  = e1 ? req1_key : req0_key;
        prev_data = e1 ? req1_data : req0_data;
        sbq.push_back('{id: e1, data: des_enc(prev_key, prev_data), avail: cyc + LAT + 2});
        m_last = e1;
      end
    end
  end

  int n_hs0 = 0, n_hs1 = 0, hs_cyc = 0;

  // One cycle: observe handshakes at negedge, then update requests and rsp_ready after the edge.
  task automatic step(input int pv0, input int pv1, input int prdy);
    logic hs0, hs1;
    @(negedge clk);
    hs0 = reset && req0_valid && req0_ready;
    hs1 = reset && req1_valid && req1_ready;
    if (hs0) begin n_hs0++; hs_cyc = cyc; end
    if (hs1) n_hs1++;
    @(posedge clk); #1;
    if (hs0) req0_valid = 1'b0;
    if (hs1) req1_valid = 1'b0;
    if (!req0_valid && ($urandom_range(99) < pv0)) begin
      req0_valid = 1'b1; req0_key = {$urandom, $urandom}; req0_data = {$urandom, $urandom};
    end
    if (!req1_valid && ($urandom_range(99) < pv1)) begin
      req1_valid = 1'b1; req1_key = {$urandom, $urandom}; req1_data = {$urandom, $urandom};
    end
    rsp_ready = ($urandom_range(99) < prdy);
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || req0_valid || req1_valid) && n < 400) begin
      step(0, 0, 100);
      n++;
    end
    check("drain_within_bound", 64'(n < 400), 64'(1));
  endtask

  initial begin
    int b, first;
    logic seen;

    // Reset held with both requesters valid; req0 must win first.
    req0_valid = 1'b1; req0_key = {$urandom, $urandom}; req0_data = {$urandom, $urandom};
    req1_valid = 1'b1; req1_key = {$urandom, $urandom}; req1_data = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    b = n_hs0;
    step(0, 0, 100);
    check("first_grant_req0", 64'(n_hs0 - b), 64'(1));
    drain();

    // Known-answer single block and its latency.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_key = 64'h133457799BBCDFF1; req0_data = 64'h0123456789ABCDEF;
    b = n_hs0;
    for (int i = 0; i < 10 && n_hs0 == b; i++) step(0, 0, 100);
    check("kat_handshake", 64'(n_hs0 - b), 64'(1));
    seen = 1'b0; first = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; first = cyc; end
    end
    check("kat_rsp_seen", 64'(seen), 64'(1));
    check("kat_latency", 64'(first - hs_cyc - 1), 64'(LAT + 1));
    check("kat_rsp_data", rsp_data, 64'h85E813540F0AB405);
    check("kat_rsp_id", 64'(rsp_id), 64'(0));
    @(negedge clk);
    check("kat_busy_after_pop", 64'(busy), 64'(0));
    @(posedge clk); #1;

    // Contention: both requesters continuously valid.
    repeat (8) step(100, 100, 100);
    drain();

    // Backpressure: only DEPTH blocks admitted while results are not consumed.
    b = n_hs0;
    repeat (30) step(100, 0, 0);
    check("backpressure_admitted", 64'(n_hs0 - b), 64'(DEPTH));
    // Single-cycle consume at full credit admits exactly one more block.
    b = n_hs0;
    step(100, 0, 100);
    repeat (6) step(100, 0, 0);
    check("credit_pulse_grants", 64'(n_hs0 - b), 64'(1));
    repeat (20) step(100, 0, 100);
    drain();

    // Reset with blocks in flight: late core outputs must be ignored.
    b = n_hs0 + n_hs1;
    for (int i = 0; i < 20 && (n_hs0 + n_hs1 - b) < 3; i++) step(100, 100, 100);
    check("midreset_blocks_issued", 64'((n_hs0 + n_hs1 - b) >= 3), 64'(1));
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) step(0, 0, 100);
    reset = 1'b0;
    repeat (2) step(0, 0, 100);
    reset = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      check("rsp_valid_after_reset", 64'(rsp_valid), 64'(0));
    end
    @(posedge clk); #1;
    step(100, 0, 100);
    drain();

    // Random traffic and consumer stalls.
    repeat (400) step(50, 50, 70);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, miscompares %0d", miscompares);
    $fatal(1, "watchdog");
  end

endmodule
